// File: rtl/dataram_pkg.sv
// Shared definitions for the bit-addressable data RAM: op codes, FSM states, bit decode.
package dataram_pkg;

    localparam logic [2:0] OP_BYTE_RD = 3'b000;
    localparam logic [2:0] OP_BYTE_WR = 3'b001;
    localparam logic [2:0] OP_BIT_RD  = 3'b010;
    localparam logic [2:0] OP_BIT_WR  = 3'b011;
    localparam logic [2:0] OP_SETB    = 3'b100;
    localparam logic [2:0] OP_CLRB    = 3'b101;
    localparam logic [2:0] OP_CPLB    = 3'b110;
    localparam logic [2:0] OP_RSVD    = 3'b111;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RMW
    } state_t;

    // Byte holding a given bit address; DW is a power of two so the divide is a shift.
    function automatic int bit2byte(input int bitAddr, input int base, input int dwLog2);
        return base + (bitAddr >> dwLog2);
    endfunction

endpackage

// File: rtl/dataram_sp.sv
// Single-port synchronous RAM, one-cycle registered read, write-first on a write cycle.
module dataram_sp #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_q           <= i_wdata;
        end else begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/bit_data_ram.sv
// MCU internal data RAM: byte space, banked Rn access and a bit-addressable region.
// Define DATARAM_BITOPS_EN to enable setb/clr/cpl read-modify-write bit ops.
module bit_data_ram
    import dataram_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 8,
    parameter int BITBASE  = 'h20,
    parameter int BITBYTES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          ready,
    input  logic [2:0]    op,
    input  logic          rn_en,
    input  logic [1:0]    bank_sel,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          wbit,
    output logic [DW-1:0] rdata,
    output logic          rbit,
    output logic          rvalid,
    output logic          err
);
    localparam int DEPTH     = 2**AW;
    localparam int BW        = $clog2(DW);
    localparam int BIT_LIMIT = BITBYTES * DW;

    state_t        r_state, w_nextState;
    logic [AW-1:0] r_initCnt;

    logic          w_accept, w_isByteOp, w_isBitOp, w_isBitRmw, w_bitOob, w_illegal;
    logic [AW-1:0] w_byteAddr, w_bitByte;
    logic [BW-1:0] w_bitIdx;

    logic          w_ramWe;
    logic [AW-1:0] w_ramAddr;
    logic [DW-1:0] w_ramWdata, w_ramQ, w_merged;

    logic [AW-1:0] r_rmwAddr;
    logic [2:0]    r_rmwOp;
    logic [BW-1:0] r_rmwIdx;
    logic          r_rmwBit;

    logic          r_pendByteRd, r_pendBitRd, r_pendErr;
    logic [BW-1:0] r_pendIdx;
    logic [DW-1:0] r_rdata;
    logic          r_rbit, r_rvalid, r_err;

    always_comb begin
        w_isBitRmw = (op == OP_BIT_WR);
`ifdef DATARAM_BITOPS_EN
        w_isBitRmw = w_isBitRmw || (op == OP_SETB) || (op == OP_CLRB) || (op == OP_CPLB);
`endif
    end

    assign w_accept   = req && ready;
    assign w_isByteOp = (op == OP_BYTE_RD) || (op == OP_BYTE_WR);
    assign w_isBitOp  = w_isBitRmw || (op == OP_BIT_RD);
    assign w_bitOob   = int'(addr) >= BIT_LIMIT;
    assign w_illegal  = (!w_isByteOp && !w_isBitOp) || (w_isBitOp && w_bitOob);
    assign w_bitByte  = AW'(bit2byte(int'(addr), BITBASE, BW));
    assign w_bitIdx   = addr[BW-1:0];
    assign w_byteAddr = rn_en ? AW'({bank_sel, addr[2:0]}) : addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_initCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_INIT) begin
                r_initCnt <= r_initCnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT: if (r_initCnt == AW'(DEPTH - 1)) w_nextState = ST_IDLE;
            ST_IDLE: if (w_accept && w_isBitRmw && !w_bitOob) w_nextState = ST_RMW;
            ST_RMW:  w_nextState = ST_IDLE;
            default: w_nextState = ST_INIT;
        endcase
    end

    always_comb begin
        ready = (r_state == ST_IDLE);
    end

    // The RAM port is shared by the clear sweep, the RMW write-back and normal requests.
    always_comb begin
        w_ramWe    = 1'b0;
        w_ramAddr  = w_isByteOp ? w_byteAddr : w_bitByte;
        w_ramWdata = wdata;
        case (r_state)
            ST_INIT: begin
                w_ramWe    = 1'b1;
                w_ramAddr  = r_initCnt;
                w_ramWdata = '0;
            end
            ST_RMW: begin
                w_ramWe    = 1'b1;
                w_ramAddr  = r_rmwAddr;
                w_ramWdata = w_merged;
            end
            default: w_ramWe = w_accept && (op == OP_BYTE_WR);
        endcase
    end

    always_comb begin
        w_merged = w_ramQ;
        case (r_rmwOp)
            OP_BIT_WR: w_merged[r_rmwIdx] = r_rmwBit;
`ifdef DATARAM_BITOPS_EN
            OP_SETB:   w_merged[r_rmwIdx] = 1'b1;
            OP_CLRB:   w_merged[r_rmwIdx] = 1'b0;
            OP_CPLB:   w_merged[r_rmwIdx] = ~w_ramQ[r_rmwIdx];
`endif
            default:   w_merged = w_ramQ;
        endcase
    end

    dataram_sp #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ramWe),
        .i_addr (w_ramAddr),
        .i_wdata(w_ramWdata),
        .o_rdata(w_ramQ)
    );

    // Reads and errors are flagged at accept and surface one edge later, once the RAM output is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rmwAddr    <= '0;
            r_rmwOp      <= OP_RSVD;
            r_rmwIdx     <= '0;
            r_rmwBit     <= 1'b0;
            r_pendByteRd <= 1'b0;
            r_pendBitRd  <= 1'b0;
            r_pendErr    <= 1'b0;
            r_pendIdx    <= '0;
            r_rdata      <= '0;
            r_rbit       <= 1'b0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_pendByteRd <= w_accept && (op == OP_BYTE_RD);
            r_pendBitRd  <= w_accept && (op == OP_BIT_RD) && !w_bitOob;
            r_pendErr    <= w_accept && w_illegal;
            r_pendIdx    <= w_bitIdx;
            if (w_accept && w_isBitRmw && !w_bitOob) begin
                r_rmwAddr <= w_bitByte;
                r_rmwOp   <= op;
                r_rmwIdx  <= w_bitIdx;
                r_rmwBit  <= wbit;
            end
            r_rvalid <= r_pendByteRd || r_pendBitRd;
            r_err    <= r_pendErr;
            if (r_pendByteRd) begin
                r_rdata <= w_ramQ;
            end
            if (r_pendBitRd) begin
                r_rbit <= w_ramQ[r_pendIdx];
            end
        end
    end

    assign rdata  = r_rdata;
    assign rbit   = r_rbit;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule

// File: tb/tb_bit_data_ram.sv
// Testbench for bit_data_ram: directed scenarios plus randomized ops against an array model.
// Expectations follow DATARAM_BITOPS_EN when the macro is defined for the build.
module tb_bit_data_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [2:0] op = 3'd0;
    logic       rn_en = 1'b0;
    logic [1:0] bank_sel = 2'd0;
    logic [7:0] addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic       wbit = 1'b0;
    logic       ready;
    logic [7:0] rdata;
    logic       rbit;
    logic       rvalid;
    logic       err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata;
    logic       exp_rbit;

    bit_data_ram dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .op(op),
        .rn_en(rn_en), .bank_sel(bank_sel), .addr(addr), .wdata(wdata), .wbit(wbit),
        .rdata(rdata), .rbit(rbit), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        exp_rdata = 8'h00;
        exp_rbit  = 1'b0;
    endtask

    // Behavioural model: applies one accepted op to the byte array and reports expected pulses.
    task automatic ref_op(input logic [2:0] o, input logic rn, input logic [1:0] bk,
                          input logic [7:0] a, input logic [7:0] wd, input logic wb,
                          output logic ev, output logic ee);
        int b;
        int k;
        bit bitOp;
        ev = 1'b0;
        ee = 1'b0;
        b = rn ? (int'(bk) * 8 + int'(a) % 8) : int'(a);
        bitOp = (o == 3'd2) || (o == 3'd3);
`ifdef DATARAM_BITOPS_EN
        bitOp = bitOp || (o >= 3'd4 && o <= 3'd6);
`endif
        if (o == 3'd0) begin
            ev = 1'b1;
            exp_rdata = ref_mem[b];
        end else if (o == 3'd1) begin
            ref_mem[b] = wd;
        end else if (!bitOp || a >= 8'd128) begin
            ee = 1'b1;
        end else begin
            b = 'h20 + int'(a) / 8;
            k = int'(a) % 8;
            case (o)
                3'd2: begin ev = 1'b1; exp_rbit = ref_mem[b][k]; end
                3'd3: ref_mem[b][k] = wb;
                3'd4: ref_mem[b][k] = 1'b1;
                3'd5: ref_mem[b][k] = 1'b0;
                default: ref_mem[b][k] = ~ref_mem[b][k];
            endcase
        end
    endtask

    // Presents a request, waits (bounded) for acceptance; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic rn, input logic [1:0] bk,
                         input logic [7:0] a, input logic [7:0] wd, input logic wb,
                         output int acc);
        int guard;
        guard = 0;
        op = o; rn_en = rn; bank_sel = bk; addr = a; wdata = wd; wbit = wb;
        req = 1'b1;
        while (ready !== 1'b1 && guard < 600) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL accept_timeout: ready=%b required 1", ready);
            acc = -1;
            req = 1'b0;
        end else begin
            @(posedge clk);
            acc = cyc;
            #1;
            req = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ready, rvalid, err, rbit, rdata} !== 12'h000) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h required 000", {ready, rvalid, err, rbit, rdata});
        end
    endtask

    task automatic test_init();
        int n;
        n = 0;
        @(negedge clk) rst_n = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ready !== 1'b1 && n < 1000);
        tests++;
        if (n !== 256) begin
            fails++;
            $display("[TB] FAIL init_length: ready rose after %0d cycles required 256", n);
        end
        model_clear();
    endtask

    task automatic test_byte_read_after_init();
        int acc;
        logic ev, ee;
        issue(3'd0, 1'b0, 2'd0, 8'h7F, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b0, 2'd0, 8'h7F, 8'h00, 1'b0, ev, ee);
        tests++;
        if (rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rd7f_early_rvalid: got %b required 0", rvalid);
        end
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h00) begin
            fails++;
            $display("[TB] FAIL rd7f: rvalid=%b rdata=%h required 1/00", rvalid, rdata);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        logic ev, ee;
        issue(3'd1, 1'b0, 2'd0, 8'h30, 8'hA5, 1'b0, a1);
        ref_op(3'd1, 1'b0, 2'd0, 8'h30, 8'hA5, 1'b0, ev, ee);
        issue(3'd0, 1'b0, 2'd0, 8'h30, 8'h00, 1'b0, a2);
        ref_op(3'd0, 1'b0, 2'd0, 8'h30, 8'h00, 1'b0, ev, ee);
        tests++;
        if (a2 !== a1 + 1) begin
            fails++;
            $display("[TB] FAIL b2b_stall: read accepted %0d cycles after write required 1", a2 - a1);
        end
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
            fails++;
            $display("[TB] FAIL b2b_read: rvalid=%b rdata=%h required 1/a5", rvalid, rdata);
        end
    endtask

    task automatic test_rn_bank();
        int acc;
        logic ev, ee;
        issue(3'd1, 1'b1, 2'd2, 8'h03, 8'h5A, 1'b0, acc);
        ref_op(3'd1, 1'b1, 2'd2, 8'h03, 8'h5A, 1'b0, ev, ee);
        issue(3'd0, 1'b0, 2'd3, 8'h13, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b0, 2'd3, 8'h13, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h5A) begin
            fails++;
            $display("[TB] FAIL rn_direct_read: rvalid=%b rdata=%h required 1/5a", rvalid, rdata);
        end
        issue(3'd1, 1'b0, 2'd0, 8'h12, 8'h33, 1'b0, acc);
        ref_op(3'd1, 1'b0, 2'd0, 8'h12, 8'h33, 1'b0, ev, ee);
        issue(3'd0, 1'b1, 2'd2, 8'hFB, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b1, 2'd2, 8'hFB, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rdata !== 8'h5A) begin
            fails++;
            $display("[TB] FAIL rn_upper_ignored: rdata=%h required 5a", rdata);
        end
    endtask

    task automatic test_bit_rmw();
        int acc;
        logic ev, ee;
        issue(3'd3, 1'b0, 2'd0, 8'h0B, 8'h00, 1'b1, acc);
        ref_op(3'd3, 1'b0, 2'd0, 8'h0B, 8'h00, 1'b1, ev, ee);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmw_ready_low: ready=%b required 0", ready);
        end
        op = 3'd1; addr = 8'h50; wdata = 8'hFF; rn_en = 1'b0; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        tests++;
        if (ready !== 1'b1 || rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmw_end: ready=%b rvalid=%b required 1/0", ready, rvalid);
        end
        issue(3'd0, 1'b0, 2'd0, 8'h21, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b0, 2'd0, 8'h21, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rdata !== 8'h08) begin
            fails++;
            $display("[TB] FAIL bitwr_byte: rdata=%h required 08", rdata);
        end
        issue(3'd0, 1'b0, 2'd0, 8'h50, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b0, 2'd0, 8'h50, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rdata !== 8'h00) begin
            fails++;
            $display("[TB] FAIL req_while_busy: rdata=%h required 00", rdata);
        end
        issue(3'd2, 1'b0, 2'd0, 8'h0B, 8'h00, 1'b0, acc);
        ref_op(3'd2, 1'b0, 2'd0, 8'h0B, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 1'b1 || rbit !== 1'b1 || rdata !== 8'h00) begin
            fails++;
            $display("[TB] FAIL bitrd_0b: rvalid=%b rbit=%b rdata=%h required 1/1/00", rvalid, rbit, rdata);
        end
        issue(3'd2, 1'b0, 2'd0, 8'h0A, 8'h00, 1'b0, acc);
        ref_op(3'd2, 1'b0, 2'd0, 8'h0A, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rbit !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bitrd_0a: rbit=%b required 0", rbit);
        end
    endtask

    task automatic test_err();
        int acc;
        logic ev, ee;
        issue(3'd2, 1'b0, 2'd0, 8'h80, 8'h00, 1'b0, acc);
        ref_op(3'd2, 1'b0, 2'd0, 8'h80, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b1 || rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bit_oob: err=%b rvalid=%b required 1/0", err, rvalid);
        end
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_pulse_width: err=%b required 0", err);
        end
        issue(3'd2, 1'b0, 2'd0, 8'h7F, 8'h00, 1'b0, acc);
        ref_op(3'd2, 1'b0, 2'd0, 8'h7F, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0 || rvalid !== 1'b1 || rbit !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bit_last: err=%b rvalid=%b rbit=%b required 0/1/0", err, rvalid, rbit);
        end
        issue(3'd7, 1'b0, 2'd0, 8'h05, 8'h00, 1'b0, acc);
        ref_op(3'd7, 1'b0, 2'd0, 8'h05, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b1 || rvalid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL op_rsvd: err=%b rvalid=%b required 1/0", err, rvalid);
        end
    endtask

    task automatic test_bitops();
        int acc;
        logic ev, ee;
        logic [7:0] expVal [2];
        logic       expErr;
`ifdef DATARAM_BITOPS_EN
        expVal[0] = 8'h01; expVal[1] = 8'h00; expErr = 1'b0;
`else
        expVal[0] = 8'h00; expVal[1] = 8'h00; expErr = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            issue(3'd6, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, acc);
            ref_op(3'd6, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, ev, ee);
            @(posedge clk); #1;
            tests++;
            if (err !== expErr) begin
                fails++;
                $display("[TB] FAIL cpl_err_%0d: err=%b required %b", k, err, expErr);
            end
            issue(3'd0, 1'b0, 2'd0, 8'h20, 8'h00, 1'b0, acc);
            ref_op(3'd0, 1'b0, 2'd0, 8'h20, 8'h00, 1'b0, ev, ee);
            @(posedge clk); #1;
            tests++;
            if (rdata !== expVal[k]) begin
                fails++;
                $display("[TB] FAIL cpl_byte_%0d: rdata=%h required %h", k, rdata, expVal[k]);
            end
        end
    endtask

    task automatic test_random();
        int acc;
        logic [2:0] o;
        logic rn, wb, ev, ee;
        logic [1:0] bk;
        logic [7:0] a, wd;
        for (int i = 0; i < 300; i++) begin
            o  = 3'($urandom_range(0, 7));
            rn = 1'($urandom_range(0, 1));
            bk = 2'($urandom_range(0, 3));
            if (o >= 3'd2) a = 8'($urandom_range(0, 143));
            else if ($urandom_range(0, 1) == 1) a = 8'(32'h20 + $urandom_range(0, 15));
            else a = 8'($urandom);
            wd = 8'($urandom);
            wb = 1'($urandom);
            issue(o, rn, bk, a, wd, wb, acc);
            ref_op(o, rn, bk, a, wd, wb, ev, ee);
            @(posedge clk); #1;
            tests++;
            if (rvalid !== ev || err !== ee) begin
                fails++;
                $display("[TB] FAIL rand_pulses[%0d] op=%0d addr=%h: rvalid=%b err=%b required %b/%b",
                         i, o, a, rvalid, err, ev, ee);
            end
            tests++;
            if (rdata !== exp_rdata) begin
                fails++;
                $display("[TB] FAIL rand_rdata[%0d] op=%0d addr=%h: rdata=%h required %h", i, o, a, rdata, exp_rdata);
            end
            if (o == 3'd2 && ev) begin
                tests++;
                if (rbit !== exp_rbit) begin
                    fails++;
                    $display("[TB] FAIL rand_rbit[%0d] addr=%h: rbit=%b required %b", i, a, rbit, exp_rbit);
                end
            end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int acc, n;
        logic ev, ee;
        issue(3'd1, 1'b0, 2'd0, 8'h40, 8'hC3, 1'b0, acc);
        issue(3'd0, 1'b0, 2'd0, 8'h40, 8'h00, 1'b0, acc);
        @(posedge clk); #1;
        issue(3'd3, 1'b0, 2'd0, 8'h05, 8'h00, 1'b1, acc);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ready, rvalid, err, rbit, rdata} !== 12'h000) begin
            fails++;
            $display("[TB] FAIL reset_mid_rmw: got %h required 000", {ready, rvalid, err, rbit, rdata});
        end
        n = 0;
        @(negedge clk) rst_n = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ready !== 1'b1 && n < 1000);
        tests++;
        if (n !== 256) begin
            fails++;
            $display("[TB] FAIL reinit_length: ready rose after %0d cycles required 256", n);
        end
        model_clear();
        issue(3'd0, 1'b0, 2'd0, 8'h40, 8'h00, 1'b0, acc);
        ref_op(3'd0, 1'b0, 2'd0, 8'h40, 8'h00, 1'b0, ev, ee);
        @(posedge clk); #1;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 8'h00) begin
            fails++;
            $display("[TB] FAIL post_reset_read: rvalid=%b rdata=%h required 1/00", rvalid, rdata);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_init();
        test_byte_read_after_init();
        test_back_to_back();
        test_rn_bank();
        test_bit_rmw();
        test_err();
        test_bitops();
        test_random();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
